// File: rtl/tlc_pkg.sv
// Shared types and encodings for the highway/farm-road intersection controller.
package tlc_pkg;

  typedef enum logic [2:0] {
    HG    = 3'd0,
    HY    = 3'd1,
    AR1   = 3'd2,
    FG    = 3'd3,
    FY    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  typedef logic [1:0] lamp_t;

  localparam lamp_t LAMP_G   = 2'b11;
  localparam lamp_t LAMP_Y   = 2'b01;
  localparam lamp_t LAMP_R   = 2'b00;
  localparam lamp_t LAMP_OFF = 2'b10;

endpackage

// File: rtl/tlc_dwell_counter.sv
// Cycles-in-state counter. It saturates at all-ones so a long highway dwell
// never wraps back below the minimum-green threshold.
module tlc_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           count <= '0;
    else if (clear)                      count <= '0;
    else if (enable && (count != '1))    count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/tlc_param_intersection.sv
// Highway/farm-road controller with all-red clearance, latched pedestrian walk
// and maintenance flash mode. Outputs are decoded from registered state only.
module tlc_param_intersection
  import tlc_pkg::*;
#(
  parameter int HG_MIN = 3,
  parameter int Y_CYC  = 1,
  parameter int AR_CYC = 1,
  parameter int FG_MAX = 2,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [1:0] h,
  output logic [1:0] f,
  output logic       walk,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] HG_LAST = CNT_W'(HG_MIN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(AR_CYC - 1);
  localparam logic [CNT_W-1:0] FG_LAST = CNT_W'(FG_MAX - 1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic               ped_pend;
  logic               flash_phase;
  logic               demand;

  assign demand = car | ped_pend;

  tlc_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clear  (next_state != state),
    .enable (1'b1),
    .count  (cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HG;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (flash_en) begin
      next_state = FLASH;
    end else begin
      case (state)
        HG:      if ((cnt >= HG_LAST) && demand)   next_state = HY;
        HY:      if (cnt >= Y_LAST)                next_state = AR1;
        AR1:     if (cnt >= AR_LAST)               next_state = FG;
        FG:      if (!demand || (cnt >= FG_LAST))  next_state = FY;
        FY:      if (cnt >= Y_LAST)                next_state = AR2;
        AR2:     if (cnt >= AR_LAST)               next_state = HG;
        FLASH:                                     next_state = AR2;
        default:                                   next_state = HG;
      endcase
    end
  end

  // Clear has priority; a request arriving in FG is dropped either way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  ped_pend <= 1'b0;
    else if ((state == FG) && (next_state == FY)) ped_pend <= 1'b0;
    else if (ped_req && (state != FG))          ped_pend <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               flash_phase <= 1'b0;
    else if (state == FLASH) flash_phase <= ~flash_phase;
    else                     flash_phase <= 1'b0;
  end

  always_comb begin
    h    = LAMP_R;
    f    = LAMP_R;
    walk = 1'b0;
    case (state)
      HG:    h = LAMP_G;
      HY:    h = LAMP_Y;
      FG: begin
        f    = LAMP_G;
        walk = ped_pend;
      end
      FY:    f = LAMP_Y;
      FLASH: begin
        h = flash_phase ? LAMP_OFF : LAMP_Y;
        f = flash_phase ? LAMP_OFF : LAMP_R;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_tlc_param_intersection.sv
// Directed bench for tlc_param_intersection: default timing, pedestrian latch,
// flash mode, asynchronous reset, and a re-parametrised instance.
module tb_tlc_param_intersection;
  import tlc_pkg::*;

  // Packed {state_o, h, f, walk}, hand-encoded.
  localparam logic [7:0] E_HG  = {3'd0, 2'b11, 2'b00, 1'b0};
  localparam logic [7:0] E_HY  = {3'd1, 2'b01, 2'b00, 1'b0};
  localparam logic [7:0] E_AR1 = {3'd2, 2'b00, 2'b00, 1'b0};
  localparam logic [7:0] E_FG  = {3'd3, 2'b00, 2'b11, 1'b0};
  localparam logic [7:0] E_FGW = {3'd3, 2'b00, 2'b11, 1'b1};
  localparam logic [7:0] E_FY  = {3'd4, 2'b00, 2'b01, 1'b0};
  localparam logic [7:0] E_AR2 = {3'd5, 2'b00, 2'b00, 1'b0};
  localparam logic [7:0] E_FLY = {3'd6, 2'b01, 2'b00, 1'b0};
  localparam logic [7:0] E_FLO = {3'd6, 2'b10, 2'b10, 1'b0};

  logic       clk = 1'b0;
  logic       reset, car, ped_req, flash_en;
  logic [1:0] h, f;
  logic       walk;
  logic [2:0] state_o;

  logic       reset_b, car_b, ped_req_b, flash_en_b;
  logic [1:0] h_b, f_b;
  logic       walk_b;
  logic [2:0] state_o_b;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_q[$];

  tlc_param_intersection dut (
    .clk(clk), .reset(reset), .car(car), .ped_req(ped_req), .flash_en(flash_en),
    .h(h), .f(f), .walk(walk), .state_o(state_o)
  );

  tlc_param_intersection #(
    .HG_MIN(5), .Y_CYC(2), .AR_CYC(2), .FG_MAX(4), .CNT_W(8)
  ) dut_b (
    .clk(clk), .reset(reset_b), .car(car_b), .ped_req(ped_req_b), .flash_en(flash_en_b),
    .h(h_b), .f(f_b), .walk(walk_b), .state_o(state_o_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed st/h/f/walk=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                tag, obs[7:5], obs[4:3], obs[2:1], obs[0], exp[7:5], exp[4:3], exp[2:1], exp[0]);
  endtask

  function automatic logic [7:0] obs_a();
    return {state_o, h, f, walk};
  endfunction

  // Reset with quiet inputs; on return the DUT is in cycle 0 after release.
  task automatic rst_a(input string tag);
    reset = 1'b1; car = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
    step();
    chk({tag, "_reset"}, obs_a(), E_HG);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; car = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
    reset_b = 1'b1; car_b = 1'b0; ped_req_b = 1'b0; flash_en_b = 1'b0;

    // Test 1: car held from cycle 0, FG capped at FG_MAX.
    rst_a("t1");
    car = 1'b1;
    exp_q = '{E_HG, E_HG, E_HG, E_HY, E_AR1, E_FG, E_FG, E_FY, E_AR2, E_HG};
    for (int c = 0; c < exp_q.size(); c++) begin
      chk($sformatf("t1_c%0d", c), obs_a(), exp_q[c]);
      step();
    end

    // Test 2: one-cycle car pulse; FG ends after a single cycle once car drops.
    rst_a("t2");
    exp_q = '{E_HG, E_HG, E_HG, E_HG, E_HG, E_HG, E_HY, E_AR1, E_FG, E_FY, E_AR2, E_HG, E_HG};
    for (int c = 0; c < exp_q.size(); c++) begin
      car = (c == 5);
      chk($sformatf("t2_c%0d", c), obs_a(), exp_q[c]);
      step();
    end
    car = 1'b0;

    // Test 3: pedestrian pulse in HG; requests during FG (incl. the clear cycle) are dropped.
    rst_a("t3");
    exp_q = '{E_HG, E_HG, E_HG, E_HY, E_AR1, E_FGW, E_FGW, E_FY, E_AR2,
              E_HG, E_HG, E_HG, E_HG, E_HG};
    for (int c = 0; c < exp_q.size(); c++) begin
      ped_req = (c == 0) || (c == 5) || (c == 6);
      chk($sformatf("t3_c%0d", c), obs_a(), exp_q[c]);
      step();
    end
    ped_req = 1'b0;

    // Test 4: flash forced from FG; a request latched in FLASH survives into the next cycle.
    rst_a("t4");
    car = 1'b1;
    exp_q = '{E_HG, E_HG, E_HG, E_HY, E_AR1, E_FG, E_FLY, E_FLO, E_FLY, E_AR2,
              E_HG, E_HG, E_HG, E_HY, E_AR1, E_FGW, E_FGW, E_FY};
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c == 5) flash_en = 1'b1;
      if (c == 8) flash_en = 1'b0;
      if (c == 9) car = 1'b0;
      ped_req = (c == 6);
      chk($sformatf("t4_c%0d", c), obs_a(), exp_q[c]);
      step();
    end

    // Test 5: asynchronous reset mid-HY takes effect before the next edge.
    rst_a("t5");
    car = 1'b1;
    step(); step(); step();
    chk("t5_hy", obs_a(), E_HY);
    #2 reset = 1'b1;
    #1 chk("t5_async", obs_a(), E_HG);
    step();
    chk("t5_held", obs_a(), E_HG);
    reset = 1'b0;
    car = 1'b0;

    // Test 6: re-parametrised instance, car held high.
    car_b = 1'b1;
    step();
    reset_b = 1'b0;
    exp_q = '{E_HG, E_HG, E_HG, E_HG, E_HG, E_HY, E_HY, E_AR1, E_AR1,
              E_FG, E_FG, E_FG, E_FG, E_FY, E_FY, E_AR2, E_AR2, E_HG};
    for (int c = 0; c < exp_q.size(); c++) begin
      chk($sformatf("t6_c%0d", c), {state_o_b, h_b, f_b, walk_b}, exp_q[c]);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
